maze_sequencer: RTL and testbench



---
 rtl/maze_pkg.sv | 20 ++
 rtl/maze_sequencer_if.sv | 24 ++
 rtl/button_conditioner.sv | 47 ++++
 rtl/maze_sequencer.sv | 141 ++++++++++++++
 tb/tb_maze_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared types and defaults for the maze sequencer and its neighbours.
package maze_pkg;

    localparam int unsigned DIM_W       = 3;
    localparam int unsigned DIM_MIN_DEF = 2;
    localparam int unsigned DIM_MAX_DEF = 7;
    localparam int unsigned DIM_DEF     = 4;

    typedef logic [DIM_W-1:0] dim_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_CARVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHOW  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/maze_sequencer_if.sv
// Sequencer-side bundle: carver handshake, latched dimensions, renderer enable and status.
interface maze_sequencer_if;
    import maze_pkg::*;

    logic   carve_start;
    logic   carve_finish;
    dim_t   x_dim;
    dim_t   y_dim;
    logic   render_enable;
    logic   busy;
    logic   error;
    state_t state;

    modport master (
        output carve_start, x_dim, y_dim, render_enable, busy, error, state,
        input  carve_finish
    );

    modport slave (
        input  carve_start, x_dim, y_dim, render_enable, busy, error, state,
        output carve_finish
    );

endinterface

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle pulse: 2-flop synchroniser, stable-count debounce, rising-edge detect.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;

            // Any sample matching the accepted level restarts the stability count.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/maze_sequencer.sv
// Sequences maze generation: conditions buttons, latches clamped dimensions,
// starts the carver, waits for a fresh finish with timeout, and gates the renderer.
module maze_sequencer
    import maze_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned MIN_DIM       = DIM_MIN_DEF,
    parameter int unsigned MAX_DIM       = DIM_MAX_DEF,
    parameter int unsigned CARVE_TIMEOUT = 1048576,
    parameter int unsigned DEF_DIM       = DIM_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_new,
    input  logic                  btn_clear,
    input  logic [DIM_W-1:0]      sw_x,
    input  logic [DIM_W-1:0]      sw_y,
    maze_sequencer_if.master      bus
);

    localparam int unsigned TMO_W = $clog2(CARVE_TIMEOUT + 1);

    function automatic dim_t clamp_dim(input dim_t v);
        if (v < dim_t'(MIN_DIM)) return dim_t'(MIN_DIM);
        if (v > dim_t'(MAX_DIM)) return dim_t'(MAX_DIM);
        return v;
    endfunction

    logic             new_p;
    logic             clear_p;
    state_t           state;
    logic             carve_start;
    logic             render_enable;
    logic             busy;
    logic             error;
    dim_t             x_dim;
    dim_t             y_dim;
    logic             seen_low;
    logic [TMO_W-1:0] tmo_cnt;

    button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_new_btn (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_new),
        .pulse (new_p)
    );

    button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear_btn (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            carve_start   <= 1'b0;
            render_enable <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            x_dim         <= dim_t'(DEF_DIM);
            y_dim         <= dim_t'(DEF_DIM);
            seen_low      <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            // NOTE: carve_start defaults low each cycle so only the LATCH->CARVE step raises it.
            carve_start <= 1'b0;

            if (clear_p) begin
                state         <= ST_IDLE;
                render_enable <= 1'b0;
                busy          <= 1'b0;
                error         <= 1'b0;
                seen_low      <= 1'b0;
                tmo_cnt       <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (new_p) begin
                            state <= ST_LATCH;
                            busy  <= 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        x_dim       <= clamp_dim(sw_x);
                        y_dim       <= clamp_dim(sw_y);
                        carve_start <= 1'b1;
                        state       <= ST_CARVE;
                    end
                    ST_CARVE: begin
                        tmo_cnt  <= '0;
                        seen_low <= 1'b0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!bus.carve_finish) seen_low <= 1'b1;
                        // A finish level is only trusted after it has been seen low in this run.
                        if (bus.carve_finish && seen_low) begin
                            state         <= ST_SHOW;
                            busy          <= 1'b0;
                            render_enable <= 1'b1;
                        end else if (tmo_cnt == TMO_W'(CARVE_TIMEOUT - 1)) begin
                            state <= ST_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (new_p) begin
                            state         <= ST_LATCH;
                            render_enable <= 1'b0;
                            busy          <= 1'b1;
                        end
                    end
                    ST_ERROR: begin
                        if (new_p) begin
                            state <= ST_LATCH;
                            error <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.carve_start   = carve_start;
    assign bus.x_dim         = x_dim;
    assign bus.y_dim         = y_dim;
    assign bus.render_enable = render_enable;
    assign bus.busy          = busy;
    assign bus.error         = error;
    assign bus.state         = state;

endmodule

// File: tb/tb_maze_sequencer.sv
// Randomised scoreboard bench for maze_sequencer: expected state-change events are queued
// from a press/finish-level model and checked by an independent monitor.
module tb_maze_sequencer;
    import maze_pkg::*;

    localparam int DB  = 4;
    localparam int TMO = 16;

    typedef struct {
        int st;
        int x;
        int y;
        int ren;
        int busy;
        int err;
        int start;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       btn_new;
    logic       btn_clear;
    logic [2:0] sw_x;
    logic [2:0] sw_y;
    int         cyc;
    int         n_checks;
    int         n_fail;
    bit         mon_en;
    exp_t       exp_q[$];

    // Model of what the design holds between runs.
    int m_x;
    int m_y;
    int m_st;

    maze_sequencer_if bus ();

    maze_sequencer #(
        .DB_CYCLES     (DB),
        .CARVE_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .btn_new   (btn_new),
        .btn_clear (btn_clear),
        .sw_x      (sw_x),
        .sw_y      (sw_y),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_ref(input int v);
        return (v < 2) ? 2 : ((v > 7) ? 7 : v);
    endfunction

    function automatic string st_name(input int s);
        case (s)
            0: return "idle";
            1: return "latch";
            2: return "carve";
            3: return "wait";
            4: return "show";
            5: return "error";
            default: return "bad";
        endcase
    endfunction

    function automatic exp_t mk(input int st, input int x, input int y, input int ren,
                                input int bsy, input int err, input int start, input int c);
        exp_t e;
        e.st = st; e.x = x; e.y = y; e.ren = ren;
        e.busy = bsy; e.err = err; e.start = start; e.cyc = c;
        return e;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic release_new_after(input int h);
        fork
            begin
                repeat (h) @(negedge clk);
                btn_new = 1'b0;
            end
        join_none
    endtask

    // Monitor: every change of the debug state is one observable event.
    initial begin
        state_t prev;
        exp_t   e;
        string  nm;
        prev = ST_IDLE;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && bus.state != prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transition", int'(bus.state), int'(prev));
                end else begin
                    e  = exp_q.pop_front();
                    nm = st_name(e.st);
                    check({nm, "_state"}, int'(bus.state), e.st);
                    check({nm, "_x_dim"}, int'(bus.x_dim), e.x);
                    check({nm, "_y_dim"}, int'(bus.y_dim), e.y);
                    check({nm, "_render_enable"}, int'(bus.render_enable), e.ren);
                    check({nm, "_busy"}, int'(bus.busy), e.busy);
                    check({nm, "_error"}, int'(bus.error), e.err);
                    check({nm, "_carve_start"}, int'(bus.carve_start), e.start);
                    if (e.cyc >= 0) check({nm, "_cycle"}, cyc, e.cyc);
                end
            end
            prev = bus.state;
        end
    end

    // mode 0: finish low before WAIT, rises after low_len WAIT cycles -> SHOW
    // mode 1: stale finish high for low_len WAIT cycles, one low cycle, then high -> SHOW
    // mode 2: stale finish never drops -> ERROR after TMO WAIT cycles
    task automatic gen(input int sx, input int sy, input int hold, input int mode, input int low_len);
        int n, w, ex, ey, last;
        sw_x = 3'(sx);
        sw_y = 3'(sy);
        bus.carve_finish = (mode == 0) ? 1'b0 : 1'b1;
        btn_new = 1'b1;
        n = cyc;
        release_new_after(hold);
        ex = clamp_ref(sx);
        ey = clamp_ref(sy);
        w  = n + DB + 6;
        exp_q.push_back(mk(int'(ST_LATCH), m_x, m_y, 0, 1, 0, 0, n + DB + 4));
        exp_q.push_back(mk(int'(ST_CARVE), ex, ey, 0, 1, 0, 1, n + DB + 5));
        exp_q.push_back(mk(int'(ST_WAIT), ex, ey, 0, 1, 0, 0, w));
        if (mode == 0) begin
            last = w + low_len + 1;
            exp_q.push_back(mk(int'(ST_SHOW), ex, ey, 1, 0, 0, 0, last));
            wait_until(w + low_len);
            bus.carve_finish = 1'b1;
            m_st = int'(ST_SHOW);
        end else if (mode == 1) begin
            last = w + low_len + 2;
            exp_q.push_back(mk(int'(ST_SHOW), ex, ey, 1, 0, 0, 0, last));
            wait_until(w + low_len);
            bus.carve_finish = 1'b0;
            wait_until(w + low_len + 1);
            bus.carve_finish = 1'b1;
            m_st = int'(ST_SHOW);
        end else begin
            last = w + TMO;
            exp_q.push_back(mk(int'(ST_ERROR), ex, ey, 0, 0, 1, 0, last));
            m_st = int'(ST_ERROR);
        end
        m_x = ex;
        m_y = ey;
        wait_until((last + 1 > n + hold + DB + 4) ? last + 1 : n + hold + DB + 4);
    endtask

    task automatic do_clear(input bit with_new);
        int n;
        btn_clear = 1'b1;
        if (with_new) btn_new = 1'b1;
        n = cyc;
        if (m_st != int'(ST_IDLE))
            exp_q.push_back(mk(int'(ST_IDLE), m_x, m_y, 0, 0, 0, 0, n + DB + 4));
        repeat (6) @(negedge clk);
        btn_clear = 1'b0;
        btn_new   = 1'b0;
        m_st = int'(ST_IDLE);
        wait_until(n + 6 + DB + 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mode, ll;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        btn_new  = 1'b0;
        btn_clear = 1'b0;
        sw_x = 3'd0;
        sw_y = 3'd0;
        bus.carve_finish = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_state", int'(bus.state), 0);
        check("reset_x_dim", int'(bus.x_dim), 4);
        check("reset_y_dim", int'(bus.y_dim), 4);
        check("reset_carve_start", int'(bus.carve_start), 0);
        check("reset_render_enable", int'(bus.render_enable), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_error", int'(bus.error), 0);

        rst_n  = 1'b1;
        m_x    = 4;
        m_y    = 4;
        m_st   = int'(ST_IDLE);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run, clamping at both ends, switches ignored while showing.
        gen(5, 3, 10, 0, 3);
        gen(0, 1, 6, 0, 2);
        gen(7, 6, 6, 0, 5);
        sw_x = 3'd1;
        sw_y = 3'd0;
        repeat (6) @(negedge clk);
        check("show_x_dim_held", int'(bus.x_dim), m_x);
        check("show_y_dim_held", int'(bus.y_dim), m_y);

        // Stale finish level, timeout, and retry from ERROR.
        gen(3, 4, 6, 1, 4);
        gen(6, 2, 6, 2, 0);
        check("error_render_enable", int'(bus.render_enable), 0);
        gen(4, 5, 7, 0, 2);

        // Clear, then a short glitch, a minimal press and a long hold.
        do_clear(1'b0);
        btn_new = 1'b1;
        repeat (2) @(negedge clk);
        btn_new = 1'b0;
        repeat (14) @(negedge clk);
        check("glitch_state_idle", int'(bus.state), 0);
        gen(2, 7, 5, 0, 3);
        gen(5, 5, 100, 0, 4);

        // Second press while waiting for the carver is dropped.
        bus.carve_finish = 1'b0;
        btn_new = 1'b1;
        n = cyc;
        release_new_after(5);
        exp_q.push_back(mk(int'(ST_LATCH), m_x, m_y, 0, 1, 0, 0, n + DB + 4));
        exp_q.push_back(mk(int'(ST_CARVE), 6, 3, 0, 1, 0, 1, n + DB + 5));
        exp_q.push_back(mk(int'(ST_WAIT), 6, 3, 0, 1, 0, 0, n + DB + 6));
        exp_q.push_back(mk(int'(ST_SHOW), 6, 3, 1, 0, 0, 0, n + DB + 19));
        sw_x = 3'd6;
        sw_y = 3'd3;
        wait_until(n + 12);
        btn_new = 1'b1;
        release_new_after(6);
        wait_until(n + DB + 18);
        bus.carve_finish = 1'b1;
        m_x = 6;
        m_y = 3;
        m_st = int'(ST_SHOW);
        wait_until(n + 30);

        // Clear and new debounced together: clear wins, dims held.
        do_clear(1'b1);
        check("clear_x_dim_held", int'(bus.x_dim), 6);
        check("clear_y_dim_held", int'(bus.y_dim), 3);

        // Randomised runs.
        for (int i = 0; i < 10; i++) begin
            mode = int'($urandom_range(0, 2));
            ll   = (mode == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
            gen(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(4, 12)), mode, ll);
        end

        // Asynchronous reset in the middle of WAIT.
        do_clear(1'b0);
        bus.carve_finish = 1'b0;
        sw_x = 3'd7;
        sw_y = 3'd2;
        btn_new = 1'b1;
        n = cyc;
        release_new_after(5);
        exp_q.push_back(mk(int'(ST_LATCH), m_x, m_y, 0, 1, 0, 0, n + DB + 4));
        exp_q.push_back(mk(int'(ST_CARVE), 7, 2, 0, 1, 0, 1, n + DB + 5));
        exp_q.push_back(mk(int'(ST_WAIT), 7, 2, 0, 1, 0, 0, n + DB + 6));
        wait_until(n + DB + 8);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_state", int'(bus.state), 0);
        check("async_reset_carve_start", int'(bus.carve_start), 0);
        check("async_reset_busy", int'(bus.busy), 0);
        check("async_reset_error", int'(bus.error), 0);
        check("async_reset_x_dim", int'(bus.x_dim), 4);
        check("async_reset_y_dim", int'(bus.y_dim), 4);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_x = 4;
        m_y = 4;
        m_st = int'(ST_IDLE);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
